// File: rtl/ram8_ctrl_if.sv
// Host-side command and response channels of the register-RAM controller.
// The host is the master; the controller is the slave.
interface ram8_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_last;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_last
    );
endinterface

// File: rtl/ram8_ctrl.sv
// Initiator-side controller for the 8x4 register RAM: host read/write/dump
// commands in, RAM pin sequencing out, read data back on a response channel.
module ram8_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int WR_LAT = 2,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    ram8_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int MAX_LAT = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dump_q, dump_d;
    logic               ready_en_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_last_q;
    logic               latch_cmd;
    logic               capture;
    logic               advance;

    // Control state: the only registers that see reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dump_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dump_q     <= dump_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dump_d    = dump_q;
        latch_cmd = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && ready_en_q) begin
                    latch_cmd = 1'b1;
                    cnt_d     = '0;
                    case (bus.cmd_op)
                        2'b00: begin state_d = RD_ADDR; dump_d = 1'b0; end
                        2'b01: begin state_d = WRITE;   dump_d = 1'b0; end
                        2'b10: begin state_d = RD_ADDR; dump_d = 1'b1; end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WRITE: begin
                if (cnt_q == CNT_W'(WR_LAT - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_ADDR: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT: begin
                // One extra cycle past RD_LAT gives mem_out a full cycle of margin.
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    capture = 1'b1;
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (!dump_q || rsp_last_q) begin
                        state_d = IDLE;
                        dump_d  = 1'b0;
                    end else begin
                        advance = 1'b1;
                        state_d = RD_ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: only meaningful while the FSM says so, outputs gate them.
    always_ff @(posedge clk) begin
        if (latch_cmd) begin
            addr_q <= (bus.cmd_op == 2'b10) ? '0 : bus.cmd_addr;
            data_q <= bus.cmd_data;
        end else if (advance) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
        if (capture) begin
            rsp_data_q <= mem_out;
            rsp_last_q <= !dump_q || (addr_q == ADDR_W'(DEPTH - 1));
        end
    end

    assign bus.cmd_ready = (state_q == IDLE) && ready_en_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = (state_q == RESP) ? rsp_data_q : '0;
    assign bus.rsp_addr  = (state_q == RESP) ? addr_q : '0;
    assign bus.rsp_last  = (state_q == RESP) ? rsp_last_q : 1'b0;

    assign mem_add  = (state_q == IDLE) ? '0 : addr_q;
    assign mem_in   = (state_q == WRITE) ? data_q : '0;
    assign mem_load = (state_q == WRITE);
    assign busy     = (state_q != IDLE);
endmodule
